// File: rtl/timer_unit.sv
`default_nettype none
// ============================================================================
//  Module   : timer_unit
//  Purpose  : Free-running cycle counter with a memory-mapped compare timer.
//             Raises a sticky, registered interrupt level (TimerInterrupt)
//             when the armed compare value equals the cycle count, and holds
//             it until software writes the acknowledge register.
//  Ports    : clock          - sole clock, rising edge
//             reset          - asynchronous, active-low
//             address        - bus byte address (exact-match decode)
//             wr_data        - bus write data
//             MemRead        - bus read strobe
//             MemWrite       - bus write strobe
//             rd_data        - combinational read data (0 when not hit)
//             TimerAddress   - high when a timer register is accessed
//             TimerInterrupt - registered interrupt level to cp0
//             cycle          - current cycle count
//  Options  : `define TIMER_PERIODIC_EN adds a period register at PERIOD_ADDR;
//             a match with a non-zero period re-arms at compare + period.
//  Revision : 1.0 - initial release
// ============================================================================
module timer_unit #(
  parameter int                 WIDTH       = 64,
  parameter logic [WIDTH-1:0]   CYCLE_ADDR  = WIDTH'(64'hFFFF001C),
  parameter logic [WIDTH-1:0]   ACK_ADDR    = WIDTH'(64'hFFFF006C),
  parameter logic [WIDTH-1:0]   PERIOD_ADDR = WIDTH'(64'hFFFF0070)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [WIDTH-1:0] rd_data,
  output logic             TimerAddress,
  output logic             TimerInterrupt,
  output logic [WIDTH-1:0] cycle
);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_armed   = 2'd1;
  localparam logic [1:0] c_st_pending = 2'd2;

`ifdef TIMER_PERIODIC_EN
  localparam logic c_periodic = 1'b1;
`else
  localparam logic c_periodic = 1'b0;
`endif

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] r_cycle;
  logic [WIDTH-1:0] r_cmp;
  logic [WIDTH-1:0] w_cmp_next;
  logic             r_irq;
  logic             w_irq_next;
  logic [WIDTH-1:0] w_period;

  logic w_access;
  logic w_hit_cycle;
  logic w_hit_ack;
  logic w_hit_period;
  logic w_wr_cycle;
  logic w_wr_ack;
  logic w_match;
  logic w_reload;

  assign w_access     = MemRead | MemWrite;
  assign w_hit_cycle  = (address == CYCLE_ADDR);
  assign w_hit_ack    = (address == ACK_ADDR);
  assign w_hit_period = c_periodic & (address == PERIOD_ADDR);
  assign w_wr_cycle   = MemWrite & w_hit_cycle;
  assign w_wr_ack     = MemWrite & w_hit_ack;

`ifdef TIMER_PERIODIC_EN
  logic [WIDTH-1:0] r_period;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_period <= '0;
    end else if (MemWrite & w_hit_period) begin
      r_period <= wr_data;
    end
  end

  assign w_period = r_period;
`else
  assign w_period = '0;
`endif

  // Compare uses the registered compare value, so a value written equal to
  // the current count only matches after the counter wraps around.
  assign w_match  = (r_state == c_st_armed) && (r_cycle == r_cmp);
  assign w_reload = |w_period;

  // State register (plus counter, compare and interrupt level)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
      r_cycle <= '0;
      r_cmp   <= '1;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cycle <= r_cycle + 1'b1;
      r_cmp   <= w_cmp_next;
      r_irq   <= w_irq_next;
    end
  end

  // Next-state logic. A match beats a same-edge ack (set wins); a compare
  // write always re-arms and replaces the value the match just used.
  always_comb begin
    w_state_next = r_state;
    w_cmp_next   = r_cmp;
    w_irq_next   = r_irq;
    if (w_match) begin
      w_irq_next = 1'b1;
      if (w_reload) begin
        w_state_next = c_st_armed;
        w_cmp_next   = r_cmp + w_period;
      end else begin
        w_state_next = c_st_pending;
      end
    end else if (w_wr_ack) begin
      w_irq_next = 1'b0;
      if (r_state == c_st_pending) begin
        w_state_next = c_st_idle;
      end
    end
    if (w_wr_cycle) begin
      w_cmp_next   = wr_data;
      w_state_next = c_st_armed;
    end
  end

  // Output logic
  always_comb begin
    TimerAddress = w_access & (w_hit_cycle | w_hit_ack | w_hit_period);
    rd_data      = '0;
    if (w_access) begin
      if (w_hit_cycle) begin
        rd_data = r_cycle;
      end else if (w_hit_period) begin
        rd_data = w_period;
      end
    end
  end

  assign TimerInterrupt = r_irq;
  assign cycle          = r_cycle;

endmodule
`default_nettype wire
